iterative_alu: RTL

Parametrised, registered successor to the single-cycle datapath ALU. Adds SRA, SLT/SLTU, and iterative signed/unsigned multiply and divide behind a start/busy/done handshake. Sits in the EX stage: single-cycle ops return in one cycle, while MULT/DIV hold the stage until done. Multiply and divide produce a double-width HI/LO result for the HI/LO register path.

---
 rtl/iterative_alu.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/iterative_alu.sv
// iterative_alu: registered EX-stage ALU. Logic/shift/compare ops finish in one cycle;
// multiply (shift-add) and divide (restoring) iterate one bit per cycle into HI/LO.
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi
);

    // state | meaning
    // IDLE  | waiting for start; short ops complete here in one cycle
    // RUN   | one multiply/divide bit step per cycle, counter counts down
    // FIX   | sign correction, HI/LO write-back, done pulse
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MULT = 4'd11;
    localparam logic [3:0] OP_MULU = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;
    localparam logic [3:0] OP_DIVU = 4'd14;

    state_t state, state_nxt;

    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   op_b;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               div_zero;

    logic               accept;
    logic               is_iter;
    logic               is_div_op;
    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   short_res;
    logic               cnt_tc;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = start && (state == IDLE);
    assign is_div_op = (operation == OP_DIV) || (operation == OP_DIVU);
    assign is_iter   = (operation == OP_MULT) || (operation == OP_MULU) || is_div_op;
    assign signed_op = (operation == OP_MULT) || (operation == OP_DIV);
    assign sign_a    = signed_op && inputA[WIDTH-1];
    assign sign_b    = signed_op && inputB[WIDTH-1];
    assign mag_a     = sign_a ? (~inputA + 1'b1) : inputA;
    assign mag_b     = sign_b ? (~inputB + 1'b1) : inputB;
    assign shamt     = inputA[SHW-1:0];
    assign cnt_tc    = (counter == CW'(1));

    always_comb begin
        short_res = '0;
        case (operation)
            OP_ADD:  short_res = inputA + inputB;
            OP_SUB:  short_res = inputA - inputB;
            OP_AND:  short_res = inputA & inputB;
            OP_OR:   short_res = inputA | inputB;
            OP_XOR:  short_res = inputA ^ inputB;
            OP_NOR:  short_res = ~(inputA | inputB);
            OP_SLL:  short_res = inputB << shamt;
            OP_SRL:  short_res = inputB >> shamt;
            OP_SRA:  short_res = $signed(inputB) >>> shamt;
            OP_SLT:  short_res = {{(WIDTH-1){1'b0}}, $signed(inputA) < $signed(inputB)};
            OP_SLTU: short_res = {{(WIDTH-1){1'b0}}, inputA < inputB};
            default: short_res = '0;
        endcase
    end

    // Multiply keeps the multiplier in acc_lo and shifts the partial product in from the top.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
    // Partial remainder is always below the divisor, so WIDTH+1 bits hold the trial difference.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, op_b};

    assign prod_mag  = {acc_hi, acc_lo};
    assign prod_fix  = neg_lo ? (~prod_mag + 1'b1) : prod_mag;
    assign quot_fix  = div_zero ? '1 : (neg_lo ? (~acc_lo + 1'b1) : acc_lo);
    assign rem_fix   = neg_hi ? (~acc_hi + 1'b1) : acc_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_iter) state_nxt = RUN;
            RUN:     if (cnt_tc) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            op_b     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            resultHi <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_iter) begin
                            counter  <= CW'(WIDTH);
                            acc_hi   <= '0;
                            acc_lo   <= mag_a;
                            op_b     <= mag_b;
                            is_div   <= is_div_op;
                            neg_lo   <= sign_a ^ sign_b;
                            neg_hi   <= sign_a;
                            div_zero <= (inputB == '0);
                        end else begin
                            result <= short_res;
                            done   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    counter <= counter - CW'(1);
                    if (is_div) begin
                        if (div_diff[WIDTH]) begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end else begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        result   <= quot_fix;
                        resultHi <= rem_fix;
                    end else begin
                        result   <= prod_fix[WIDTH-1:0];
                        resultHi <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
